// File: rtl/psola_playback_ctrl.sv
// rtl/psola_playback_ctrl.sv - ping-pong output buffer controller between PSOLA generator and audio sinks
module psola_playback_ctrl #(
    parameter int MAX_EXTENDED  = 2200,
    parameter int SAMPLE_PERIOD = 2304,
    parameter int RD_LATENCY    = 2,
    parameter int AW            = $clog2(MAX_EXTENDED),
    parameter int BW            = $clog2(2 * MAX_EXTENDED)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [31:0]   wr_data_in,
    input  logic [AW-1:0] wr_addr_in,
    input  logic          wr_valid_in,
    input  logic          wr_done_in,
    output logic [BW-1:0] bram_wr_addr_out,
    output logic [31:0]   bram_wr_data_out,
    output logic          bram_wr_en_out,
    output logic [BW-1:0] bram_rd_addr_out,
    input  logic [31:0]   bram_rd_data_in,
    output logic [31:0]   sample_out,
    output logic          sample_valid_out,
    output logic          bank_out,
    output logic          playing_out,
    output logic [15:0]   underrun_count_out,
    output logic          overflow_out
);

    // Frame lengths must hold the value MAX_EXTENDED itself, so they get one more code than addresses.
    localparam int LW = $clog2(MAX_EXTENDED + 1);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [BW-1:0] BANK1_BASE = BW'(MAX_EXTENDED);

    logic [TW-1:0]       tick;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       play_len;
    logic [LW-1:0]       wr_len;
    logic [LW-1:0]       wr_len_next;
    logic [LW-1:0]       wr_end;
    // tok_pipe marks a sample slot travelling alongside the BRAM read; live_pipe says whether it was a real read.
    logic [RD_LATENCY:0] tok_pipe;
    logic [RD_LATENCY:0] live_pipe;
    logic                tick_end;
    logic                wr_ok;
    logic                swap;
    logic                issue;
    logic                at_wrap;

    // Decode the per-cycle events: sample tick, accepted write, frame swap, read issue and frame wrap.
    always_comb begin
        tick_end    = (tick == TW'(SAMPLE_PERIOD - 1));
        wr_ok       = wr_valid_in && ({1'b0, wr_addr_in} < (AW + 1)'(MAX_EXTENDED));
        wr_end      = LW'(wr_addr_in) + LW'(1);
        wr_len_next = wr_len;
        if (wr_ok && (wr_end > wr_len)) begin
            wr_len_next = wr_end;
        end
        // A write landing with the done pulse still belongs to the finishing frame.
        swap    = wr_done_in && (wr_len_next != '0);
        issue   = tick_end && playing_out;
        at_wrap = ((LW'(rd_ptr) + LW'(1)) == play_len);
    end

    // Free-running sample-rate divider; frame swaps never touch it so output pacing stays fixed.
    always_ff @(posedge clk_in) begin
        if (rst_in || tick_end) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // Port A: register the steered write one cycle later; out-of-range writes are dropped and flagged.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bram_wr_en_out   <= 1'b0;
            bram_wr_addr_out <= '0;
            bram_wr_data_out <= '0;
            overflow_out     <= 1'b0;
        end else begin
            bram_wr_en_out <= wr_ok;
            if (wr_ok) begin
                bram_wr_addr_out <= BW'(wr_addr_in) + (bank_out ? BANK1_BASE : '0);
                bram_wr_data_out <= wr_data_in;
            end
            if (wr_valid_in && !wr_ok) begin
                overflow_out <= 1'b1;
            end
        end
    end

    // Frame bookkeeping: bank swap, frame lengths, read pointer with looping and underrun counting.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bank_out           <= 1'b0;
            playing_out        <= 1'b0;
            wr_len             <= '0;
            play_len           <= '0;
            rd_ptr             <= '0;
            underrun_count_out <= '0;
            bram_rd_addr_out   <= '0;
        end else begin
            if (issue) begin
                // The read half is always the bank the writer is not using.
                bram_rd_addr_out <= BW'(rd_ptr) + (bank_out ? '0 : BANK1_BASE);
            end
            if (swap) begin
                bank_out    <= ~bank_out;
                playing_out <= 1'b1;
                play_len    <= wr_len_next;
                wr_len      <= '0;
                rd_ptr      <= '0;
            end else begin
                wr_len <= wr_len_next;
                if (issue) begin
                    if (at_wrap) begin
                        rd_ptr <= '0;
                        if (underrun_count_out != 16'hFFFF) begin
                            underrun_count_out <= underrun_count_out + 16'd1;
                        end
                    end else begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                end
            end
        end
    end

    // Output side: slots exit the pipe when BRAM data is on port B; idle slots emit zero at the same offset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tok_pipe         <= '0;
            live_pipe        <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            tok_pipe         <= {tok_pipe[RD_LATENCY-1:0], tick_end};
            live_pipe        <= {live_pipe[RD_LATENCY-1:0], issue};
            sample_valid_out <= tok_pipe[RD_LATENCY];
            if (tok_pipe[RD_LATENCY]) begin
                sample_out <= live_pipe[RD_LATENCY] ? bram_rd_data_in : 32'd0;
            end
        end
    end

endmodule
